// File: rtl/sprite_palette_ram_pkg.sv
// Shared types for the sprite palette RAM.
//   rgb_t           : 24-bit 8:8:8 colour
//   state_t         : init sequencer states
//   KEY_RGB_DEFAULT : default transparency key colour
package sprite_palette_ram_pkg;

  typedef logic [23:0] rgb_t;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_IDLE = 1'b1
  } state_t;

  localparam rgb_t KEY_RGB_DEFAULT = 24'h800080;

endpackage

// File: rtl/sprite_palette_ram_palette_store.sv
// Palette colour storage: DEPTH x 24, one write port, one synchronous read
// port. A read and a write to the same address in one cycle return the old
// contents.
//   clk_i    : clock
//   we_i     : write enable
//   waddr_i  : write address
//   wdata_i  : write colour
//   raddr_i  : read address
//   rdata_o  : registered read colour (one cycle after raddr_i)
module palette_store
  import sprite_palette_ram_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  rgb_t          wdata_i,
  input  logic [AW-1:0] raddr_i,
  output rgb_t          rdata_o
);

  rgb_t mem_q [DEPTH];
  rgb_t rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/sprite_palette_ram.sv
// Sprite palette RAM: NUM_PAL palettes of ENTRIES 24-bit colours with a
// pipelined lookup (one request per cycle) and a transparency-key flag.
// After reset an init sequencer clears every entry, one per cycle.
//   Clk, Reset            : clock, synchronous active-high reset
//   wr_en/wr_pal/wr_idx/wr_rgb : palette write (ignored while busy)
//   rd_valid_in/rd_pal/rd_idx  : lookup request
//   fade_level            : per-request brightness shift (fade build only)
//   rd_valid_out/rd_rgb/rd_transparent : lookup result
//   busy                  : init sequencer active
// Optional feature: define PALETTE_FADE_EN to add a fade output stage
// (latency 3 instead of 2).
module sprite_palette_ram
  import sprite_palette_ram_pkg::*;
#(
  parameter int   IDX_W   = 8,
  parameter int   ENTRIES = 16,
  parameter int   NUM_PAL = 4,
  parameter rgb_t KEY_RGB = KEY_RGB_DEFAULT
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic                       wr_en,
  input  logic [$clog2(NUM_PAL)-1:0] wr_pal,
  input  logic [IDX_W-1:0]           wr_idx,
  input  rgb_t                       wr_rgb,
  input  logic                       rd_valid_in,
  input  logic [$clog2(NUM_PAL)-1:0] rd_pal,
  input  logic [IDX_W-1:0]           rd_idx,
  input  logic [2:0]                 fade_level,
  output logic                       rd_valid_out,
  output rgb_t                       rd_rgb,
  output logic                       rd_transparent,
  output logic                       busy
);

  localparam int PW    = $clog2(NUM_PAL);
  localparam int DEPTH = NUM_PAL * ENTRIES;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef PALETTE_FADE_EN
  localparam int STAGES = 3;
`else
  localparam int STAGES = 2;
`endif

  // Linear address: palettes laid out back to back, ENTRIES each.
  function automatic logic [AW-1:0] addr_of(input logic [PW-1:0] p,
                                            input logic [IDX_W-1:0] i);
    return AW'(p) * AW'(ENTRIES) + AW'(i);
  endfunction

  // ---------------- init sequencer ----------------
  state_t        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_INIT: begin
        if (cnt_q == AW'(DEPTH - 1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  logic in_init;
  assign in_init = (state_q == ST_INIT);
  assign busy    = in_init;

  // ---------------- storage ----------------
  logic          wr_ok, rd_ok, st_we;
  logic [AW-1:0] st_waddr, st_raddr;
  rgb_t          st_wdata, st_rdata;

  assign wr_ok    = wr_en && !in_init && !Reset &&
                    ({1'b0, wr_idx} < (IDX_W+1)'(ENTRIES));
  assign rd_ok    = !in_init && ({1'b0, rd_idx} < (IDX_W+1)'(ENTRIES));
  assign st_we    = in_init || wr_ok;
  assign st_waddr = in_init ? cnt_q : addr_of(wr_pal, wr_idx);
  assign st_wdata = in_init ? '0 : wr_rgb;
  // Out-of-range requests read a safe address; the result is forced to 0.
  assign st_raddr = rd_ok ? addr_of(rd_pal, rd_idx) : '0;

  palette_store #(.DEPTH(DEPTH), .AW(AW)) u_store (
    .clk_i   (Clk),
    .we_i    (st_we),
    .waddr_i (st_waddr),
    .wdata_i (st_wdata),
    .raddr_i (st_raddr),
    .rdata_o (st_rdata)
  );

  // ---------------- lookup pipeline ----------------
  logic [STAGES:1] vld_pipe_q;
  logic            hit1_q;  // request is in range and was made outside INIT
  rgb_t            rgb2_q;
  logic            tr2_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      vld_pipe_q <= '0;
      hit1_q     <= 1'b0;
      rgb2_q     <= '0;
      tr2_q      <= 1'b0;
    end else begin
      vld_pipe_q <= {vld_pipe_q[STAGES-1:1], rd_valid_in};
      hit1_q     <= rd_valid_in && rd_ok;
      if (vld_pipe_q[1] && hit1_q) begin
        rgb2_q <= st_rdata;
        tr2_q  <= (st_rdata == KEY_RGB);
      end else begin
        rgb2_q <= '0;
        tr2_q  <= 1'b0;
      end
    end
  end

  assign rd_valid_out = vld_pipe_q[STAGES];

`ifdef PALETTE_FADE_EN
  logic [2:0] fade1_q, fade2_q;
  rgb_t       rgb3_q;
  logic       tr3_q;

  function automatic rgb_t fade(input rgb_t c, input logic [2:0] s);
    return {c[23:16] >> s, c[15:8] >> s, c[7:0] >> s};
  endfunction

  // fade_level travels with its request; transparency uses the pre-fade colour.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      fade1_q <= '0;
      fade2_q <= '0;
      rgb3_q  <= '0;
      tr3_q   <= 1'b0;
    end else begin
      fade1_q <= fade_level;
      fade2_q <= fade1_q;
      rgb3_q  <= vld_pipe_q[2] ? fade(rgb2_q, fade2_q) : '0;
      tr3_q   <= vld_pipe_q[2] && tr2_q;
    end
  end

  assign rd_rgb         = rgb3_q;
  assign rd_transparent = tr3_q;
`else
  logic unused_fade;
  assign unused_fade    = ^fade_level;
  assign rd_rgb         = rgb2_q;
  assign rd_transparent = tr2_q;
`endif

endmodule

// File: tb/tb_sprite_palette_ram.sv
module tb_sprite_palette_ram;

  localparam int IDX_W   = 8;
  localparam int ENTRIES = 16;
  localparam int NUM_PAL = 4;
  localparam int DEPTH   = NUM_PAL * ENTRIES;
  localparam logic [23:0] KEY = 24'h800080;
`ifdef PALETTE_FADE_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic        Clk, Reset, wr_en, rd_valid_in;
  logic [1:0]  wr_pal, rd_pal;
  logic [7:0]  wr_idx, rd_idx;
  logic [23:0] wr_rgb, rd_rgb;
  logic [2:0]  fade_level;
  logic        rd_valid_out, rd_transparent, busy;

  sprite_palette_ram dut (
    .Clk(Clk), .Reset(Reset), .wr_en(wr_en), .wr_pal(wr_pal), .wr_idx(wr_idx),
    .wr_rgb(wr_rgb), .rd_valid_in(rd_valid_in), .rd_pal(rd_pal), .rd_idx(rd_idx),
    .fade_level(fade_level), .rd_valid_out(rd_valid_out), .rd_rgb(rd_rgb),
    .rd_transparent(rd_transparent), .busy(busy)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct { logic [23:0] rgb; logic tr; int due; } exp_t;
  exp_t        sb[$];
  logic [23:0] model [NUM_PAL][ENTRIES];
  int          tests = 0, fails = 0;
  int          cyc = 0;
  int          init_left = 0;
  bit          mon_en = 0;

  always @(posedge Clk) cyc <= cyc + 1;

  // Scoreboard monitor: every result must match the oldest expectation,
  // arrive on its due cycle, and idle outputs must be zero.
  always @(negedge Clk) begin
    if (mon_en) begin
      tests++;
      if (rd_valid_out === 1'b1) begin
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL unexpected_valid: rd_valid_out=1 rgb=%h with no request pending (cycle %0d)", rd_rgb, cyc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (rd_rgb !== e.rgb || rd_transparent !== e.tr || cyc !== e.due) begin
            fails++;
            $display("FAIL lookup: got rgb=%h tr=%b cycle=%0d, expected rgb=%h tr=%b cycle=%0d",
                     rd_rgb, rd_transparent, cyc, e.rgb, e.tr, e.due);
          end
        end
      end else if (rd_valid_out !== 1'b0 || rd_rgb !== 24'h0 || rd_transparent !== 1'b0) begin
        fails++;
        $display("FAIL idle_outputs: valid=%b rgb=%h tr=%b, expected 0/000000/0",
                 rd_valid_out, rd_rgb, rd_transparent);
      end
    end
  end

  task automatic clear_model();
    for (int p = 0; p < NUM_PAL; p++)
      for (int i = 0; i < ENTRIES; i++) model[p][i] = 24'h0;
  endtask

  // One cycle of stimulus; expectation computed from the pre-write model.
  task automatic drive(input logic we, input int wp, input int wi, input logic [23:0] wv,
                       input logic re, input int rp, input int ri, input int fl);
    exp_t e;
    logic [23:0] c;
    bit ini;
    @(negedge Clk);
    wr_en = we; wr_pal = 2'(wp); wr_idx = 8'(wi); wr_rgb = wv;
    rd_valid_in = re; rd_pal = 2'(rp); rd_idx = 8'(ri); fade_level = 3'(fl);
    ini = (init_left > 0);
    if (re) begin
      c = (ini || ri >= ENTRIES) ? 24'h0 : model[rp][ri];
      e.tr = (c == KEY);
`ifdef PALETTE_FADE_EN
      e.rgb = {c[23:16] >> fl, c[15:8] >> fl, c[7:0] >> fl};
`else
      e.rgb = c;
`endif
      e.due = cyc + LAT;
      sb.push_back(e);
    end
    if (we && !ini && wi < ENTRIES) model[wp][wi] = wv;
    if (init_left > 0) init_left--;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(0, 0, 0, 24'h0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Reset = 1'b1; wr_en = 0; rd_valid_in = 0;
    @(posedge Clk);
    #1 sb.delete();
    repeat (3) @(negedge Clk);
    Reset = 1'b0;
    clear_model();
    init_left = DEPTH - 1;
  endtask

  task automatic test_reset();
    int n;
    repeat (3) @(posedge Clk);
    mon_en = 1;
    @(negedge Clk);
    tests++;
    if (busy !== 1'b1) begin
      fails++; $display("FAIL reset_busy: busy=%b, expected 1", busy);
    end
    Reset = 1'b0;
    clear_model();
    n = 0;
    while (busy === 1'b1 && n < 200) begin n++; @(negedge Clk); end
    tests++;
    if (n !== DEPTH) begin
      fails++; $display("FAIL busy_cycles: busy high %0d cycles, expected %0d", n, DEPTH);
    end
    init_left = 0;
    drive(0, 0, 0, 24'h0, 1, 0, 0, 0);
    drive(0, 0, 0, 24'h0, 1, 3, 15, 0);
    drive(0, 0, 0, 24'h0, 1, 2, 7, 0);
    idle(LAT + 1);
  endtask

  task automatic test_write_read();
    drive(1, 2, 5, 24'h3d4137, 0, 0, 0, 0);
    drive(0, 0, 0, 24'h0, 1, 2, 5, 0);
    drive(1, 0, 0, KEY, 0, 0, 0, 0);
    drive(0, 0, 0, 24'h0, 1, 0, 0, 0);
    idle(LAT + 1);
  endtask

  task automatic test_rbw();
    drive(1, 1, 7, 24'ha54a06, 0, 0, 0, 0);
    drive(1, 1, 7, 24'hcb896f, 1, 1, 7, 0);
    drive(0, 0, 0, 24'h0, 1, 1, 7, 0);
    idle(LAT + 1);
  endtask

  task automatic test_back_to_back();
    drive(1, 3, 15, 24'h123456, 0, 0, 0, 0);
    drive(1, 3, 20, 24'hffffff, 1, 2, 5, 0);
    drive(0, 0, 0, 24'h0, 1, 3, 20, 0);
    drive(0, 0, 0, 24'h0, 1, 3, 15, 0);
    drive(0, 0, 0, 24'h0, 1, 1, 255, 0);
    drive(0, 0, 0, 24'h0, 1, 0, 0, 0);
    drive(0, 0, 0, 24'h0, 1, 0, 16, 0);
    idle(LAT + 1);
  endtask

  task automatic test_random();
    for (int k = 0; k < 60; k++)
      drive($urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 19),
            ($urandom_range(0, 7) == 0) ? KEY : 24'($urandom),
            $urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 19),
            $urandom_range(0, 7));
    idle(LAT + 1);
  endtask

  task automatic test_init_reads();
    do_reset();
    drive(1, 1, 3, 24'habcdef, 1, 2, 5, 0);
    drive(0, 0, 0, 24'h0, 1, 1, 3, 0);
    drive(1, 0, 2, 24'h777777, 1, 0, 0, 0);
    while (init_left > 0) drive(0, 0, 0, 24'h0, 1, 1, 3, 0);
    drive(0, 0, 0, 24'h0, 1, 1, 3, 0);
    drive(0, 0, 0, 24'h0, 1, 0, 2, 0);
    idle(LAT + 1);
  endtask

  task automatic test_reset_midstream();
    drive(1, 2, 9, 24'h456789, 0, 0, 0, 0);
    drive(0, 0, 0, 24'h0, 1, 2, 9, 0);
    drive(0, 0, 0, 24'h0, 1, 2, 9, 1);
    drive(0, 0, 0, 24'h0, 1, 2, 9, 2);
    do_reset();
    tests++;
    if (rd_valid_out !== 1'b0 || busy !== 1'b1) begin
      fails++; $display("FAIL reset_flush: valid=%b busy=%b, expected 0/1", rd_valid_out, busy);
    end
    while (init_left > 0) drive(0, 0, 0, 24'h0, 0, 0, 0, 0);
    drive(0, 0, 0, 24'h0, 1, 2, 9, 0);
    idle(LAT + 1);
  endtask

`ifdef PALETTE_FADE_EN
  task automatic test_fade();
    drive(1, 3, 4, 24'he7a688, 0, 0, 0, 0);
    drive(0, 0, 0, 24'h0, 1, 3, 4, 2);
    drive(0, 0, 0, 24'h0, 1, 3, 4, 7);
    drive(1, 0, 1, KEY, 1, 3, 4, 0);
    drive(0, 0, 0, 24'h0, 1, 0, 1, 3);
    idle(LAT + 1);
  endtask
`endif

  initial begin
    Reset = 1'b1; wr_en = 0; wr_pal = 0; wr_idx = 0; wr_rgb = 0;
    rd_valid_in = 0; rd_pal = 0; rd_idx = 0; fade_level = 0;
    test_reset();
    test_write_read();
    test_rbw();
    test_back_to_back();
`ifdef PALETTE_FADE_EN
    test_fade();
`endif
    test_random();
    test_init_reads();
    test_reset_midstream();
    idle(4);
    tests++;
    if (sb.size() != 0) begin
      fails++; $display("FAIL drain: %0d results outstanding, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
